// File: rtl/run_ctrl_pkg.sv
// Shared types for the run sequencer: FSM state encoding and trace FIFO sizing helpers.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        GAP,
        START,
        RUN,
        FIN
    } run_state_e;

    localparam int unsigned TRACE_DEPTH_DEFAULT = 16;
    localparam int unsigned TRACE_LVL_W_DEFAULT = $clog2(TRACE_DEPTH_DEFAULT) + 1;

    // Occupancy needs one bit more than the pointers so that "full" is representable.
    function automatic int unsigned trace_lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/run_trace_fifo.sv
// First-word-fall-through store trace FIFO with sticky overflow flag.
// RUN_CTRL_TRACE_TIMESTAMP_EN adds a CNT_W timestamp to every entry; otherwise head_time is 0.
module run_trace_fifo import run_ctrl_pkg::*; #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = trace_lvl_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic [CNT_W-1:0]  push_time,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  head_time,
    output logic [LVL_W-1:0]  level,
    output logic              overflow
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
`ifdef RUN_CTRL_TRACE_TIMESTAMP_EN
        logic [CNT_W-1:0]  stamp;
`endif
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            wr_entry;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              overflow_q;
    logic              do_push;
    logic              do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    // A pop frees the slot a simultaneous push needs, so push-while-full succeeds if popping.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_entry      = '0;
        wr_entry.addr = push_addr;
        wr_entry.data = push_data;
`ifdef RUN_CTRL_TRACE_TIMESTAMP_EN
        wr_entry.stamp = push_time;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_entry;
    end

    assign head_addr = mem[rd_ptr_q].addr;
    assign head_data = mem[rd_ptr_q].data;
    assign level     = level_q;
    assign overflow  = overflow_q;

`ifdef RUN_CTRL_TRACE_TIMESTAMP_EN
    assign head_time = mem[rd_ptr_q].stamp;
`else
    logic [CNT_W-1:0] unused_push_time;
    assign unused_push_time = push_time;
    assign head_time        = '0;
`endif

endmodule

// File: rtl/run_controller.sv
// Run sequencer for the 9-bit CPU: reset/start handshake, cycle counter, watchdog, store trace.
// RUN_CTRL_TRACE_TIMESTAMP_EN enables per-entry timestamps in the trace FIFO.
module run_controller import run_ctrl_pkg::*; #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned TRACE_DEPTH  = 16,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           go,
    input  logic                           cpu_done,
    input  logic                           d_we,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic [DATA_W-1:0]              d_wdata,
    output logic                           cpu_reset,
    output logic                           cpu_start,
    output logic                           busy,
    output logic                           pass,
    output logic                           timeout,
    output logic [CNT_W-1:0]               cycle_count,
    output logic                           trace_valid,
    input  logic                           trace_pop,
    output logic [ADDR_W-1:0]              trace_addr,
    output logic [DATA_W-1:0]              trace_data,
    output logic [CNT_W-1:0]               trace_time,
    output logic [$clog2(TRACE_DEPTH):0]   trace_level,
    output logic                           trace_overflow
);

    localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);

    run_state_e        state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d, count_inc;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic              fifo_clear;
    logic              fifo_push;
    logic              fifo_empty;
    logic              unused_fifo_full;

    assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        count_d    = count_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        fifo_clear = 1'b0;
        fifo_push  = 1'b0;
        cpu_reset  = 1'b0;
        cpu_start  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            IDLE, FIN: begin
                cpu_reset = (state_q == IDLE);
                if (go) begin
                    state_d    = RST;
                    rst_cnt_d  = '0;
                    count_d    = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    fifo_clear = 1'b1;
                end
            end
            RST: begin
                cpu_reset = 1'b1;
                busy      = 1'b1;
                if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) state_d = GAP;
                else rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
            GAP: begin
                busy    = 1'b1;
                state_d = START;
            end
            START: begin
                busy      = 1'b1;
                cpu_start = 1'b1;
                fifo_push = d_we;
                count_d   = count_inc;
                state_d   = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                fifo_push = d_we;
                // cpu_done takes priority over the watchdog; the count holds at the limit on timeout.
                if (cpu_done) begin
                    pass_d  = 1'b1;
                    count_d = count_inc;
                    state_d = FIN;
                end else if (count_q == CNT_W'(MAX_CYCLES)) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    count_d = count_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rst_cnt_q <= '0;
            count_q   <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            count_q   <= count_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    run_trace_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_addr (d_addr),
        .push_data (d_wdata),
        .push_time (count_q),
        .pop       (trace_pop),
        .full      (unused_fifo_full),
        .empty     (fifo_empty),
        .head_addr (trace_addr),
        .head_data (trace_data),
        .head_time (trace_time),
        .level     (trace_level),
        .overflow  (trace_overflow)
    );

    assign trace_valid = !fifo_empty;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed self-checking bench for run_controller (MAX_CYCLES=50, TRACE_DEPTH=4).
module tb_run_controller;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned TRACE_DEPTH  = 4;
    localparam int unsigned RESET_CYCLES = 2;
    localparam int unsigned MAX_CYCLES   = 50;
    localparam int unsigned CNT_W        = 16;
`ifdef RUN_CTRL_TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic                         go = 1'b0;
    logic                         cpu_done = 1'b0;
    logic                         d_we = 1'b0;
    logic [ADDR_W-1:0]            d_addr = '0;
    logic [DATA_W-1:0]            d_wdata = '0;
    logic                         trace_pop = 1'b0;
    logic                         cpu_reset, cpu_start, busy, pass, timeout;
    logic [CNT_W-1:0]             cycle_count;
    logic                         trace_valid;
    logic [ADDR_W-1:0]            trace_addr;
    logic [DATA_W-1:0]            trace_data;
    logic [CNT_W-1:0]             trace_time;
    logic [$clog2(TRACE_DEPTH):0] trace_level;
    logic                         trace_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    int          store_k    [3] = '{2, 5, 9};
    logic [7:0]  store_data [3] = '{8'h11, 8'h22, 8'h33};
    logic        exp_rst    [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        exp_start  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    run_controller #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .TRACE_DEPTH  (TRACE_DEPTH),
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .go             (go),
        .cpu_done       (cpu_done),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .cpu_reset      (cpu_reset),
        .cpu_start      (cpu_start),
        .busy           (busy),
        .pass           (pass),
        .timeout        (timeout),
        .cycle_count    (cycle_count),
        .trace_valid    (trace_valid),
        .trace_pop      (trace_pop),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_time     (trace_time),
        .trace_level    (trace_level),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From IDLE/FIN: pulse go and advance to the START cycle.
    task automatic launch();
        go = 1'b1;
        tick();
        go = 1'b0;
        check("launch_busy", 32'(busy), 1);
        check("launch_clr_count", 32'(cycle_count), 0);
        check("launch_clr_pass", 32'(pass), 0);
        check("launch_clr_timeout", 32'(timeout), 0);
        check("launch_clr_level", 32'(trace_level), 0);
        check("launch_clr_ovf", 32'(trace_overflow), 0);
        repeat (3) tick();
        check("launch_start", 32'(cpu_start), 1);
    endtask

    task automatic pop_expect(input logic [7:0] a, input logic [7:0] d, input int unsigned t);
        check("pop_valid", 32'(trace_valid), 1);
        check("pop_addr", 32'(trace_addr), 32'(a));
        check("pop_data", 32'(trace_data), 32'(d));
        check("pop_time", 32'(trace_time), TS_EN ? t : 0);
        trace_pop = 1'b1;
        tick();
        trace_pop = 1'b0;
    endtask

    // Three stores, cpu_done on the 20th RUN cycle, then drain the trace.
    task automatic normal_run();
        int s;
        s = 0;
        launch();
        for (int k = 1; k <= 20; k++) begin
            tick();
            d_we = 1'b0;
            if (s < 3 && k == store_k[s]) begin
                d_we    = 1'b1;
                d_addr  = ADDR_W'(s);
                d_wdata = store_data[s];
                s++;
            end
            cpu_done = (k == 20);
        end
        tick();
        d_we     = 1'b0;
        cpu_done = 1'b0;
        check("norm_pass", 32'(pass), 1);
        check("norm_timeout", 32'(timeout), 0);
        check("norm_count", 32'(cycle_count), 21);
        check("norm_busy", 32'(busy), 0);
        check("norm_cpu_reset", 32'(cpu_reset), 0);
        for (int i = 0; i < 3; i++) begin
            check("norm_level", 32'(trace_level), 32'(3 - i));
            pop_expect(8'(i), store_data[i], store_k[i]);
        end
        check("norm_level_empty", 32'(trace_level), 0);
        check("norm_valid_empty", 32'(trace_valid), 0);
    endtask

    initial begin
        int ncyc;

        // Reset values and launch sequence
        tick();
        tick();
        check("rst_cpu_reset", 32'(cpu_reset), 1);
        check("rst_cpu_start", 32'(cpu_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_count", 32'(cycle_count), 0);
        check("rst_valid", 32'(trace_valid), 0);
        check("rst_level", 32'(trace_level), 0);
        check("rst_ovf", 32'(trace_overflow), 0);
        reset = 1'b0;
        tick();
        check("idle_cpu_reset", 32'(cpu_reset), 1);
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("seq_cpu_reset", 32'(cpu_reset), 32'(exp_rst[i]));
            check("seq_cpu_start", 32'(cpu_start), 32'(exp_start[i]));
            check("seq_busy", 32'(busy), 1);
            if (i < 4) tick();
        end
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        check("seq_fin_pass", 32'(pass), 1);

        // Normal completion
        normal_run();

        // Watchdog, with an ignored go mid-run
        launch();
        ncyc = 0;
        tick();
        while (busy === 1'b1 && ncyc < 100) begin
            ncyc++;
            go = (ncyc == 10);
            tick();
        end
        go = 1'b0;
        check("wd_run_cycles", 32'(ncyc), 50);
        check("wd_timeout", 32'(timeout), 1);
        check("wd_pass", 32'(pass), 0);
        check("wd_count", 32'(cycle_count), 50);
        check("wd_busy", 32'(busy), 0);

        // cpu_done on the cycle the limit is reached
        launch();
        for (int k = 1; k <= 50; k++) tick();
        check("tie_count_at_limit", 32'(cycle_count), 50);
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        check("tie_pass", 32'(pass), 1);
        check("tie_timeout", 32'(timeout), 0);
        check("tie_count", 32'(cycle_count), 51);

        // FIFO overflow: six stores into four entries
        launch();
        for (int k = 1; k <= 6; k++) begin
            tick();
            d_we    = 1'b1;
            d_addr  = ADDR_W'(10 + k);
            d_wdata = DATA_W'(8'hA0 + k);
        end
        tick();
        d_we     = 1'b0;
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        check("ovf_level", 32'(trace_level), 4);
        check("ovf_flag", 32'(trace_overflow), 1);
        for (int i = 1; i <= 4; i++) pop_expect(8'(10 + i), 8'(8'hA0 + i), i);
        trace_pop = 1'b1;
        tick();
        trace_pop = 1'b0;
        check("ovf_pop_empty_level", 32'(trace_level), 0);
        check("ovf_sticky", 32'(trace_overflow), 1);

        // Push and pop together while full
        launch();
        for (int k = 1; k <= 4; k++) begin
            tick();
            d_we    = 1'b1;
            d_addr  = ADDR_W'(20 + k);
            d_wdata = DATA_W'(8'hB0 + k);
        end
        tick();
        check("pp_full_level", 32'(trace_level), 4);
        d_we      = 1'b1;
        d_addr    = 8'd25;
        d_wdata   = 8'hB5;
        trace_pop = 1'b1;
        tick();
        d_we      = 1'b0;
        trace_pop = 1'b0;
        check("pp_level", 32'(trace_level), 4);
        check("pp_ovf", 32'(trace_overflow), 0);
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        for (int i = 2; i <= 5; i++) pop_expect(8'(20 + i), 8'(8'hB0 + i), i);

        // Asynchronous abort mid-RUN, then relaunch
        launch();
        for (int k = 1; k <= 5; k++) begin
            tick();
            d_we    = (k == 3);
            d_addr  = 8'd7;
            d_wdata = 8'h77;
        end
        d_we = 1'b0;
        check("abort_pre_count", 32'(cycle_count), 5);
        check("abort_pre_level", 32'(trace_level), 1);
        #2 reset = 1'b1;
        #1;
        check("abort_cpu_reset", 32'(cpu_reset), 1);
        check("abort_cpu_start", 32'(cpu_start), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_pass", 32'(pass), 0);
        check("abort_timeout", 32'(timeout), 0);
        check("abort_count", 32'(cycle_count), 0);
        check("abort_valid", 32'(trace_valid), 0);
        check("abort_level", 32'(trace_level), 0);
        check("abort_ovf", 32'(trace_overflow), 0);
        tick();
        reset = 1'b0;
        tick();
        normal_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary in time");
        $fatal(1);
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Synthesizable run sequencer and execution monitor for the 9-bit CPU top level.
- Drives the CPU's reset/start handshake, counts execution cycles and enforces a watchdog timeout.
- Captures every data-memory store into a trace FIFO.
- Reports pass/timeout status, so directed program runs can be checked on-chip or by a thin bench.

Parameters:
DATA_W, 8, width of store data captured from the data memory port
ADDR_W, 8, width of store address captured
TRACE_DEPTH, 16, trace FIFO entries (power of two, >=2)
RESET_CYCLES, 2, cycles cpu_reset is held high after go
MAX_CYCLES, 1000, watchdog limit in counted cycles (must be < 2**CNT_W)
CNT_W, 16, cycle counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
go  input  1  single-cycle request to launch a run
cpu_done  input  1  CPU done flag
d_we  input  1  CPU data-memory write enable
d_addr  input  ADDR_W  CPU data-memory address
d_wdata  input  DATA_W  CPU data-memory write data
cpu_reset  output  1  reset to CPU
cpu_start  output  1  one-cycle start pulse to CPU
busy  output  1  run in progress
pass  output  1  sticky: run ended by cpu_done
timeout  output  1  sticky: run ended by watchdog
cycle_count  output  CNT_W  cycles counted in current/last run
trace_valid  output  1  FIFO non-empty
trace_pop  input  1  pop head entry
trace_addr  output  ADDR_W  head entry address
trace_data  output  DATA_W  head entry data
trace_time  output  CNT_W  head entry timestamp (see option)
trace_level  output  $clog2(TRACE_DEPTH)+1  occupancy
trace_overflow  output  1  sticky: store dropped while full

Behaviour:
- Clock is clk; reset is asynchronous and active-high, applied by the port named reset.
- Reset values: state IDLE; cpu_reset=1; all other outputs 0; FIFO empty.
- Reset asserted mid-run aborts immediately to these values.
- FSM states and transitions:
  - IDLE: cpu_reset=1. go -> RST.
  - RST: cpu_reset=1 for exactly RESET_CYCLES cycles, then -> GAP.
  - GAP: cpu_reset=0 for 1 cycle -> START.
  - START: cpu_start=1 for exactly 1 cycle -> RUN.
  - RUN: wait for the end condition.
    - cpu_done=1 -> FIN with pass=1.
    - Else cycle_count==MAX_CYCLES -> FIN with timeout=1.
    - cpu_done and limit in the same cycle: pass wins, timeout stays 0.
  - FIN: cpu_reset=0; pass/timeout/cycle_count/FIFO held. go -> RST (new run).
- busy=1 in RST, GAP, START, RUN.
- go while busy is ignored.
- go (accepted in IDLE or FIN) clears pass, timeout, cycle_count, FIFO contents and trace_overflow on the cycle RST is entered.
- cycle_count:
  - Increments by 1 on every clock in START and RUN.
  - Frozen in all other states.
  - Saturates at all-ones; no wrap.
- Trace capture:
  - Push when d_we=1 in START or RUN; an entry is {d_addr, d_wdata, cycle_count sampled same cycle}.
  - Output is first-word-fall-through: head entry visible on trace_addr/data/time whenever trace_valid=1.
  - trace_pop pops the head on the next edge.
  - Pop while empty is ignored.
  - Push while full without a simultaneous pop: entry dropped, trace_overflow set sticky.
  - Push and pop in the same cycle while full: both occur, level unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo TRACE_DEPTH.
  - Popping is allowed in every state, including FIN and IDLE.
- Output data when trace_valid=0: unspecified but stable; the bench must not check it.

Optional Feature:
RUN_CTRL_TRACE_TIMESTAMP_EN
- Defined: FIFO stores the CNT_W timestamp per entry and trace_time presents it.
- Undefined: timestamp storage is not instantiated and trace_time is tied to 0.
- All other behaviour is identical in both builds.

Decomposition:
- Package run_ctrl_pkg holds:
  - state enum run_state_e {IDLE, RST, GAP, START, RUN, FIN};
  - parametrised trace entry struct fields (addr, data, time);
  - localparam for occupancy width.
- One sub-module, run_trace_fifo: synchronous FWFT FIFO with push/pop/full/empty/level/overflow, same clk/reset.
- The FSM and counter stay in run_controller.

Test Plan:
1. Reset and launch: reset high, then go pulse.
   - cpu_reset high for exactly 2 cycles, low 1 cycle, then cpu_start high exactly 1 cycle.
   - busy=1 from RST through RUN.
2. Normal completion: cpu_done raised on the 20th RUN cycle with 3 stores (addr 0,1,2; data 8'h11, 8'h22, 8'h33).
   - pass=1, timeout=0, cycle_count=21 (START cycle plus 20 RUN cycles).
   - FIFO pops 0/11, 1/22, 2/33 in order.
   - trace_level drops 3->0.
3. Watchdog with MAX_CYCLES=50: cpu_done never asserted.
   - timeout=1 with cycle_count=50, pass=0, busy=0.
   - A go during the run is ignored.
4. Tie: cpu_done asserted on the exact cycle cycle_count==MAX_CYCLES.
   - pass=1, timeout=0.
5. FIFO boundaries, TRACE_DEPTH=4: 6 stores with no pops.
   - level=4, trace_overflow=1, and the first 4 entries are retained.
   - Repeat the test with pop and push together while full: level stays 4 and overflow stays 0.
6. Abort and relaunch: async reset mid-RUN.
   - All outputs return to reset values within the same cycle.
   - A second go after reset and a new run behaves as in scenario 2.
   - With RUN_CTRL_TRACE_TIMESTAMP_EN defined, trace_time equals the cycle_count value sampled when each store was captured.
